// File: rtl/seq_mult_shift_add_if.sv
// Handshake and operand/result bundle for seq_mult_shift_add.
interface seq_mult_shift_add_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic               start;
  logic               sgn;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (
    output start, sgn, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, sgn, a, b,
    output busy, done, p
  );
endinterface

// File: rtl/seq_mult_shift_add.sv
// Sequential shift-and-add multiplier: one WIDTH-bit add per cycle on operand magnitudes,
// with the sign applied by a conditional two's-complement negate when the result is stored.
module seq_mult_shift_add #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  seq_mult_shift_add_if.slave bus
);
  localparam int unsigned CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_step;

  // Magnitudes fit in WIDTH bits unsigned, including the most negative value.
  always_comb begin
    mag_a = (bus.sgn && bus.a[WIDTH-1]) ? (~bus.a + WIDTH'(1)) : bus.a;
    mag_b = (bus.sgn && bus.b[WIDTH-1]) ? (~bus.b + WIDTH'(1)) : bus.b;
  end

  // acc = {hi, lo}; the adder carry becomes the new top bit after the right shift.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_step = {sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    p_d     = p_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          mcand_d = mag_a;
          acc_d   = {{WIDTH{1'b0}}, mag_b};
          neg_d   = bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          p_d     = neg_q ? (~acc_step + (2*WIDTH)'(1)) : acc_step;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = (state_q == StDone);
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_mult_shift_add.sv
// Self-checking bench for seq_mult_shift_add: WIDTH=8 and WIDTH=4 instances against an
// arithmetic reference model and directed handshake/reset scenarios.
module tb_seq_mult_shift_add;
  logic clk = 1'b0;
  logic rst_n;
  int   tests_run    = 0;
  int   tests_failed = 0;

  seq_mult_shift_add_if #(.WIDTH(8)) i8 ();
  seq_mult_shift_add_if #(.WIDTH(4)) i4 ();

  seq_mult_shift_add #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(i8));
  seq_mult_shift_add #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4));

  always #5 clk = ~clk;

  // Directed vectors: width, signed, a, b, expected product.
  int unsigned dv_w[8]   = '{8, 8, 8, 8, 8, 4, 4, 4};
  bit          dv_s[8]   = '{0, 1, 1, 1, 1, 0, 1, 1};
  logic [31:0] dv_a[8]   = '{32'hFF, 32'hFD, 32'h80, 32'h80, 32'h00, 32'hF, 32'h8, 32'h7};
  logic [31:0] dv_b[8]   = '{32'hFF, 32'h05, 32'h80, 32'h7F, 32'hFF, 32'hF, 32'h8, 32'h8};
  logic [31:0] dv_exp[8] = '{32'hFE01, 32'hFFF1, 32'h4000, 32'hC080, 32'h0000,
                             32'hE1, 32'h40, 32'hC8};

  // Reference: interpret operands as w-bit integers, multiply, keep 2*w bits.
  function automatic logic [31:0] model(input int w, input bit s, input logic [31:0] av,
                                        input logic [31:0] bv);
    longint m, x, y;
    m = (longint'(1) << w) - 1;
    x = longint'(av) & m;
    y = longint'(bv) & m;
    if (s && x >= (longint'(1) << (w - 1))) x = x - (longint'(1) << w);
    if (s && y >= (longint'(1) << (w - 1))) y = y - (longint'(1) << w);
    return 32'((x * y) & ((longint'(1) << (2 * w)) - 1));
  endfunction

  task automatic drive(input int w, input bit st, input bit s, input logic [31:0] av,
                       input logic [31:0] bv);
    if (w == 8) begin
      i8.start = st; i8.sgn = s; i8.a = av[7:0]; i8.b = bv[7:0];
    end else begin
      i4.start = st; i4.sgn = s; i4.a = av[3:0]; i4.b = bv[3:0];
    end
  endtask

  function automatic bit get_busy(input int w);
    return (w == 8) ? i8.busy : i4.busy;
  endfunction

  function automatic bit get_done(input int w);
    return (w == 8) ? i8.done : i4.done;
  endfunction

  function automatic logic [31:0] get_p(input int w);
    return (w == 8) ? {16'h0, i8.p} : {24'h0, i4.p};
  endfunction

  // One operation: start for a single cycle, then scramble inputs to show they are ignored.
  // lat counts edges after the start-sampling edge until done is seen.
  task automatic op(input int w, input bit s, input logic [31:0] av, input logic [31:0] bv,
                    output logic [31:0] pv, output int lat, output int nbusy,
                    output bit post_busy, output bit post_done, output logic [31:0] post_p);
    @(negedge clk);
    drive(w, 1'b1, s, av, bv);
    @(posedge clk); #1;
    drive(w, 1'b0, 1'($urandom), $urandom, $urandom);
    lat   = 0;
    nbusy = int'(get_busy(w));
    while (!get_done(w) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      nbusy += int'(get_busy(w));
    end
    pv = get_p(w);
    @(posedge clk); #1;
    post_busy = get_busy(w);
    post_done = get_done(w);
    post_p    = get_p(w);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++; if (i8.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy8: got %b want 0", i8.busy); end
    tests_run++; if (i8.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done8: got %b want 0", i8.done); end
    tests_run++; if (i8.p !== 16'h0) begin tests_failed++; $display("FAIL reset_p8: got %h want 0", i8.p); end
    tests_run++; if (i4.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy4: got %b want 0", i4.busy); end
    tests_run++; if (i4.p !== 8'h0) begin tests_failed++; $display("FAIL reset_p4: got %h want 0", i4.p); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (i8.busy !== 1'b0) begin tests_failed++; $display("FAIL idle_busy8: got %b want 0", i8.busy); end
  endtask

  task automatic test_basic;
    logic [31:0] pv, pp;
    int lat, nb;
    bit pb, pd;
    op(8, 1'b0, 32'd13, 32'd11, pv, lat, nb, pb, pd, pp);
    tests_run++; if (pv !== 32'h8F) begin tests_failed++; $display("FAIL basic_p: got %h want 008f", pv); end
    tests_run++; if (lat !== 8) begin tests_failed++; $display("FAIL basic_latency: got %0d want 8", lat); end
    tests_run++; if (nb !== 9) begin tests_failed++; $display("FAIL basic_busy_cycles: got %0d want 9", nb); end
    tests_run++; if (pb !== 1'b0) begin tests_failed++; $display("FAIL basic_busy_after: got %b want 0", pb); end
    tests_run++; if (pd !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse: got %b want 0", pd); end
    tests_run++; if (pp !== 32'h8F) begin tests_failed++; $display("FAIL basic_p_hold: got %h want 008f", pp); end
  endtask

  task automatic test_directed;
    logic [31:0] pv, pp;
    int lat, nb;
    bit pb, pd;
    for (int i = 0; i < 8; i++) begin
      op(int'(dv_w[i]), dv_s[i], dv_a[i], dv_b[i], pv, lat, nb, pb, pd, pp);
      tests_run++;
      if (pv !== dv_exp[i]) begin
        tests_failed++;
        $display("FAIL directed_p[%0d]: got %h want %h", i, pv, dv_exp[i]);
      end
      tests_run++;
      if (lat !== int'(dv_w[i])) begin
        tests_failed++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, dv_w[i]);
      end
    end
  endtask

  // Starts during RUN and in the DONE cycle are dropped; a start held across the
  // busy->idle boundary is taken on the first idle edge.
  task automatic test_handshake;
    int ndone = 0, k1 = -1, k2 = -1;
    logic [15:0] p1 = '0, p2 = '0;
    for (int k = 0; k <= 21; k++) begin
      @(negedge clk);
      if (k == 0)       drive(8, 1'b1, 1'b0, 32'd7, 32'd6);
      else if (k == 3)  drive(8, 1'b1, 1'b0, 32'd2, 32'd2);
      else if (k == 9)  drive(8, 1'b1, 1'b0, 32'd2, 32'd2);
      else if (k == 10) drive(8, 1'b1, 1'b0, 32'd9, 32'd9);
      else              drive(8, 1'b0, 1'b0, 32'd2, 32'd2);
      @(posedge clk); #1;
      if (i8.done) begin
        ndone++;
        if (ndone == 1) begin k1 = k; p1 = i8.p; end
        else if (ndone == 2) begin k2 = k; p2 = i8.p; end
      end
    end
    tests_run++; if (ndone !== 2) begin tests_failed++; $display("FAIL hs_done_count: got %0d want 2", ndone); end
    tests_run++; if (k1 !== 8) begin tests_failed++; $display("FAIL hs_first_done_edge: got %0d want 8", k1); end
    tests_run++; if (p1 !== 16'd42) begin tests_failed++; $display("FAIL hs_first_p: got %0d want 42", p1); end
    tests_run++; if (k2 !== 18) begin tests_failed++; $display("FAIL hs_second_done_edge: got %0d want 18", k2); end
    tests_run++; if (p2 !== 16'd81) begin tests_failed++; $display("FAIL hs_second_p: got %0d want 81", p2); end
  endtask

  task automatic test_random;
    logic [31:0] pv, pp, av, bv, exp;
    int lat, nb, w;
    bit pb, pd, s;
    for (int i = 0; i < 50; i++) begin
      w  = (i < 30) ? 8 : 4;
      s  = 1'($urandom);
      av = $urandom;
      bv = $urandom;
      exp = model(w, s, av, bv);
      op(w, s, av, bv, pv, lat, nb, pb, pd, pp);
      tests_run++;
      if (pv !== exp) begin
        tests_failed++;
        $display("FAIL random_p w=%0d s=%0d a=%h b=%h: got %h want %h", w, s,
                 av & ((32'd1 << w) - 1), bv & ((32'd1 << w) - 1), pv, exp);
      end
      tests_run++;
      if (lat !== w) begin
        tests_failed++;
        $display("FAIL random_latency w=%0d: got %0d want %0d", w, lat, w);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] pv, pp;
    int lat, nb;
    bit pb, pd;
    @(negedge clk);
    drive(8, 1'b1, 1'b0, 32'd100, 32'd100);
    @(posedge clk); #1;
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #2;
    tests_run++; if (i8.busy !== 1'b1) begin tests_failed++; $display("FAIL midrst_busy_before: got %b want 1", i8.busy); end
    rst_n = 1'b0;
    #1;
    tests_run++; if (i8.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b want 0", i8.busy); end
    tests_run++; if (i8.done !== 1'b0) begin tests_failed++; $display("FAIL midrst_done: got %b want 0", i8.done); end
    tests_run++; if (i8.p !== 16'h0) begin tests_failed++; $display("FAIL midrst_p: got %h want 0", i8.p); end
    @(negedge clk);
    rst_n = 1'b1;
    op(8, 1'b0, 32'd5, 32'd5, pv, lat, nb, pb, pd, pp);
    tests_run++; if (pv !== 32'd25) begin tests_failed++; $display("FAIL midrst_fresh_p: got %0d want 25", pv); end
    tests_run++; if (lat !== 8) begin tests_failed++; $display("FAIL midrst_fresh_latency: got %0d want 8", lat); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(4, 1'b0, 1'b0, 32'd0, 32'd0);
    test_reset();
    test_basic();
    test_directed();
    test_handshake();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
